dmem_arbiter: RTL and testbench

- Shares the single-port data RAM between the CPU data port and one external requester (program loader / debug port).
- Sits between the CPU's MemWrite/ALUResult/WriteData/ReadData signals and the data RAM's we/a/wd/rd signals.
- Stalls the CPU while the RAM is busy.
- CPU has fixed priority; a starvation counter bounds the external requester's wait.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_arb_starve_ctr.sv | 34 +++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   state_t  : arbiter FSM states
//   owner_t  : which requester owns the RAM port in the current cycle
//   DMEM_N_DEF : default address/data width
//   STARVE_W   : width of the external-requester starvation counter
package dmem_arb_pkg;

   localparam int unsigned DMEM_N_DEF = 32;
   localparam int unsigned STARVE_W   = 8;
   localparam int unsigned GRANT_W    = 16;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      RD_CPU = 2'd1,
      RD_EXT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_t;

   // Saturating increment for the grant statistics counters.
   function automatic logic [GRANT_W-1:0] sat_inc16(input logic [GRANT_W-1:0] v);
      return (v == {GRANT_W{1'b1}}) ? v : v + GRANT_W'(1);
   endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating wait counter for the external requester.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   i_inc           : external requester waited this cycle
//   i_clr           : external requester granted or idle (wins over i_inc)
//   o_starved_c     : counter has reached STARVE_LIMIT
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_starved_c
);

   logic [STARVE_W-1:0] r_cnt;

   // Clear has priority; increment sticks at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {STARVE_W{1'b1}})) begin
         r_cnt <= r_cnt + STARVE_W'(1);
      end
   end

   assign o_starved_c = (r_cnt >= STARVE_W'(STARVE_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous-read data RAM between the
// CPU data port (fixed priority) and one external requester whose wait is
// bounded by a starvation counter.
// Ports:
//   clk, reset                       : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata            : CPU access request
//   cpu_rdata, cpu_ready             : CPU read data / access complete
//   ext_valid/we/addr/wdata          : external access request
//   ext_ready                        : external request issued to RAM
//   ext_rvalid, ext_rdata            : external read return pulse / data
//   mem_we/addr/wdata, mem_rdata     : RAM port (read data one cycle late)
//   cpu_grant_cnt, ext_grant_cnt     : grant statistics, only when
//                                      DMEM_ARB_STATS_EN is defined
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned N            = DMEM_N_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cpu_req,
   input  logic         cpu_we,
   input  logic [N-1:0] cpu_addr,
   input  logic [N-1:0] cpu_wdata,
   output logic [N-1:0] cpu_rdata,
   output logic         cpu_ready,
   input  logic         ext_valid,
   input  logic         ext_we,
   input  logic [N-1:0] ext_addr,
   input  logic [N-1:0] ext_wdata,
   output logic         ext_ready,
   output logic         ext_rvalid,
   output logic [N-1:0] ext_rdata,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]  cpu_grant_cnt,
   output logic [15:0]  ext_grant_cnt
`endif
);

   state_t       r_state;
   state_t       w_state_nxt;
   owner_t       w_owner;
   logic         w_starved;
   logic         w_ext_grant;
   logic [N-1:0] r_cpu_rdata;
   logic [N-1:0] r_ext_rdata;

   dmem_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk         (clk),
      .reset       (reset),
      .i_inc       (ext_valid & ~w_ext_grant),
      .i_clr       (~ext_valid | w_ext_grant),
      .o_starved_c (w_starved)
   );

   assign w_ext_grant = (w_owner == OWN_EXT);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ARB;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant decision, RAM drive and handshakes. Everything is gated by reset
   // so the combinational outputs drop to 0 the moment reset asserts.
   always_comb begin
      w_state_nxt = r_state;
      w_owner     = OWN_NONE;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      cpu_ready   = 1'b0;
      ext_ready   = 1'b0;
      if (reset) begin
         case (r_state)
            ARB: begin
               if (ext_valid && w_starved) begin
                  w_owner = OWN_EXT;
               end else if (cpu_req) begin
                  w_owner = OWN_CPU;
               end else if (ext_valid) begin
                  w_owner = OWN_EXT;
               end
               case (w_owner)
                  OWN_CPU: begin
                     mem_we    = cpu_we;
                     mem_addr  = cpu_addr;
                     mem_wdata = cpu_wdata;
                     cpu_ready = cpu_we;
                     if (!cpu_we) w_state_nxt = RD_CPU;
                  end
                  OWN_EXT: begin
                     mem_we    = ext_we;
                     mem_addr  = ext_addr;
                     mem_wdata = ext_wdata;
                     ext_ready = 1'b1;
                     if (!ext_we) w_state_nxt = RD_EXT;
                  end
                  default: ;
               endcase
            end
            RD_CPU: begin
               cpu_ready   = 1'b1;
               w_state_nxt = ARB;
            end
            RD_EXT: begin
               w_state_nxt = ARB;
            end
            default: begin
               w_state_nxt = ARB;
            end
         endcase
      end
   end

   // Read-data holding registers: capture the RAM word on its return cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpu_rdata <= '0;
         r_ext_rdata <= '0;
      end else begin
         if (r_state == RD_CPU) r_cpu_rdata <= mem_rdata;
         if (r_state == RD_EXT) r_ext_rdata <= mem_rdata;
      end
   end

   // Return cycle passes the RAM word straight through; otherwise hold.
   assign cpu_rdata  = (r_state == RD_CPU) ? mem_rdata : r_cpu_rdata;
   assign ext_rdata  = (r_state == RD_EXT) ? mem_rdata : r_ext_rdata;
   assign ext_rvalid = (r_state == RD_EXT);

`ifdef DMEM_ARB_STATS_EN
   logic [GRANT_W-1:0] r_cpu_grant_cnt;
   logic [GRANT_W-1:0] r_ext_grant_cnt;

   // Saturating per-requester grant counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpu_grant_cnt <= '0;
         r_ext_grant_cnt <= '0;
      end else begin
         if (w_owner == OWN_CPU) r_cpu_grant_cnt <= sat_inc16(r_cpu_grant_cnt);
         if (w_owner == OWN_EXT) r_ext_grant_cnt <= sat_inc16(r_ext_grant_cnt);
      end
   end

   assign cpu_grant_cnt = r_cpu_grant_cnt;
   assign ext_grant_cnt = r_ext_grant_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read RAM model and
// read-return scoreboards for both requesters.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready;
   logic        ext_valid, ext_we;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        ext_ready, ext_rvalid;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cpu_grant_cnt, ext_grant_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] ram     [0:255];
   logic [31:0] exp_mem [0:255];
   logic [31:0] cpu_q [$];
   logic [31:0] ext_q [$];

   always #5 clk = ~clk;

   dmem_arbiter u_dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .ext_valid  (ext_valid),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_ready  (ext_ready),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .cpu_grant_cnt (cpu_grant_cnt),
      .ext_grant_cnt (ext_grant_cnt)
`endif
   );

   // Synchronous-read RAM, preloaded with a known pattern while in reset.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
      end else if (mem_we) begin
         ram[mem_addr[9:2]] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr[9:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pop scoreboards whenever the DUT returns read data.
   task automatic sample_ret();
      logic [31:0] e;
      if (cpu_ready && !cpu_we) begin
         if (cpu_q.size() == 0) chk("cpu_ret_unexpected", 32'(cpu_ready), 32'd0);
         else begin e = cpu_q.pop_front(); chk("cpu_rdata", cpu_rdata, e); end
      end
      if (ext_rvalid) begin
         if (ext_q.size() == 0) chk("ext_ret_unexpected", 32'(ext_rvalid), 32'd0);
         else begin e = ext_q.pop_front(); chk("ext_rdata", ext_rdata, e); end
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #2;
      sample_ret();
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ext_valid = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
   endtask

   function automatic logic [3:0] hs();
      return {mem_we, cpu_ready, ext_ready, ext_rvalid};
   endfunction

   initial begin
      bit          exp_cr [7] = '{1, 1, 1, 1, 0, 0, 1};
      bit          exp_er [7] = '{0, 0, 0, 0, 1, 0, 0};
      bit          exp_rv [7] = '{0, 0, 0, 0, 0, 1, 0};
      int          wi;
      logic [31:0] d;

      for (int i = 0; i < 256; i++) exp_mem[i] = 32'hA500_0000 | 32'(i);
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);

      // Reset holds every output low even with live requests.
      #2;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
      ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h14;
      #2;
      chk("rst_handshakes", 32'(hs()), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_ext_rdata", ext_rdata, 32'd0);
      idle_inputs();
      #1 reset = 1'b1;

      // CPU write alone completes in one cycle.
      next();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
      settle();
      chk("cpu_wr_handshakes", 32'(hs()), 32'b1100);
      chk("cpu_wr_addr", mem_addr, 32'h10);
      chk("cpu_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (cpu_ready) exp_mem[4] = 32'hDEAD_BEEF;

      // CPU read of the same word returns on the second cycle.
      next();
      cpu_we = 1'b0;
      cpu_q.push_back(exp_mem[4]);
      settle();
      chk("cpu_rd_issue_ready", 32'(cpu_ready), 32'd0);
      chk("cpu_rd_issue_addr", mem_addr, 32'h10);
      next();
      settle();
      chk("cpu_rd_ret_ready", 32'(cpu_ready), 32'd1);
      chk("cpu_rd_ret_we", 32'(mem_we), 32'd0);
      next();
      cpu_req = 1'b0;
      settle();
      chk("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

      // Simultaneous requests with no starvation: CPU read first, EXT waits 2.
      next();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h24; ext_wdata = 32'h1234_5678;
      cpu_q.push_back(exp_mem[8]);
      settle();
      chk("both_c1_ext_ready", 32'(ext_ready), 32'd0);
      chk("both_c1_addr", mem_addr, 32'h20);
      next();
      settle();
      chk("both_c2_hs", 32'(hs()), 32'b0100);
      next();
      cpu_req = 1'b0;
      settle();
      chk("both_c3_hs", 32'(hs()), 32'b1010);
      chk("both_c3_addr", mem_addr, 32'h24);
      if (ext_ready) exp_mem[9] = 32'h1234_5678;

      // EXT read back of its own write.
      next();
      ext_we = 1'b0;
      ext_q.push_back(exp_mem[9]);
      settle();
      chk("ext_rd_issue_ready", 32'(ext_ready), 32'd1);
      next();
      ext_valid = 1'b0;
      settle();
      chk("ext_rd_rvalid", 32'(ext_rvalid), 32'd1);
      next();
      settle();
      chk("ext_rvalid_pulse", 32'(ext_rvalid), 32'd0);
      chk("ext_rdata_hold", ext_rdata, 32'h1234_5678);

      // Starvation: back-to-back CPU writes, EXT read forced through on cycle 5.
      wi = 0;
      for (int k = 0; k < 7; k++) begin
         next();
         cpu_req = 1'b1; cpu_we = 1'b1;
         cpu_addr = 32'h80 + 32'(wi * 4); cpu_wdata = 32'hC0DE_0000 + 32'(wi);
         if (k == 0) begin
            ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
            ext_q.push_back(exp_mem[16]);
         end
         if (k >= 5) ext_valid = 1'b0;
         settle();
         chk($sformatf("starve_k%0d_cpu_ready", k), 32'(cpu_ready), 32'(exp_cr[k]));
         chk($sformatf("starve_k%0d_ext_ready", k), 32'(ext_ready), 32'(exp_er[k]));
         chk($sformatf("starve_k%0d_rvalid", k), 32'(ext_rvalid), 32'(exp_rv[k]));
         if (cpu_ready) begin
            exp_mem[32 + wi] = 32'hC0DE_0000 + 32'(wi);
            wi++;
         end
      end
      chk("starve_cpu_writes", 32'(wi), 32'd5);

      // CPU read; dropping cpu_req during the return cycle changes nothing.
      next();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8C;
      cpu_q.push_back(exp_mem[35]);
      settle();
      chk("rd8c_issue_ready", 32'(cpu_ready), 32'd0);
      next();
      cpu_req = 1'b0;
      settle();
      chk("rd8c_ret_ready", 32'(cpu_ready), 32'd1);

      // Reset during RD_EXT: response dropped, outputs clear asynchronously.
      next();
      ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h44;
      settle();
      chk("rst_rd_issue", 32'(ext_ready), 32'd1);
      next();
      ext_valid = 1'b0;
      reset = 1'b0;
      settle();
      chk("rst_rd_hs", 32'(hs()), 32'd0);
      chk("rst_rd_ext_rdata", ext_rdata, 32'd0);
      chk("rst_rd_cpu_rdata", cpu_rdata, 32'd0);
      next();
      reset = 1'b1;

      // Idle for 10 cycles.
      for (int k = 0; k < 10; k++) begin
         next();
         settle();
         chk($sformatf("idle_%0d_hs", k), 32'(hs()), 32'd0);
      end

      // After idle the counter is 0, so the CPU wins a simultaneous request.
      next();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h0000_0100;
      ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h104; ext_wdata = 32'h0000_0104;
      settle();
      chk("post_idle_hs", 32'(hs()), 32'b1100);
      chk("post_idle_addr", mem_addr, 32'h100);
      next();
      cpu_req = 1'b0;
      settle();
      chk("post_idle_ext_hs", 32'(hs()), 32'b1010);
      chk("post_idle_ext_addr", mem_addr, 32'h104);
      if (ext_ready) exp_mem[65] = 32'h0000_0104;
      next();
      ext_valid = 1'b0;
      cpu_req = 1'b1; cpu_addr = 32'h108; cpu_wdata = 32'h0000_0108;
      settle();
      next();
      cpu_addr = 32'h10C; cpu_wdata = 32'h0000_010C;
      settle();
      next();
      cpu_req = 1'b0;
      ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h110; ext_wdata = 32'h0000_0110;
      settle();
      chk("ext_wr2_ready", 32'(ext_ready), 32'd1);
      next();
      ext_valid = 1'b0;
      settle();
`ifdef DMEM_ARB_STATS_EN
      chk("cpu_grant_cnt", 32'(cpu_grant_cnt), 32'd3);
      chk("ext_grant_cnt", 32'(ext_grant_cnt), 32'd2);
`endif

      // EXT read back of the post-idle write.
      next();
      ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h104;
      ext_q.push_back(exp_mem[65]);
      settle();
      next();
      ext_valid = 1'b0;
      settle();
      d = 32'(cpu_q.size());
      chk("cpu_q_drained", d, 32'd0);
      d = 32'(ext_q.size());
      chk("ext_q_drained", d, 32'd0);

      next();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
